spe_tx_arbiter: RTL and testbench
=================================

Name: spe_tx_arbiter

Overview:
- Clocked round-robin arbiter that shares one SPE packetizer input among NUM_REQ requesters, e.g. parallel SPE functional-block lanes or a local control/debug source.
- Each requester presents a destination address, opcode and payload. The block grants one requester at a time, registers the fields and holds them on the packetizer side until they are accepted.
- A bounded burst lock lets a granted requester send up to MAX_BURST back-to-back packets before the grant rotates.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 4, destination address width.
- OP_W, 4, opcode width.
- DATA_W, 25, payload width.
- MAX_BURST, 4, maximum consecutive packets per grant (>=1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester packet valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_dest  in  NUM_REQ*ADDR_W  packed dest addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_opcode  in  NUM_REQ*OP_W  packed opcodes.
- req_data  in  NUM_REQ*DATA_W  packed payloads.
- out_valid  out  1  packet valid toward packetizer.
- out_ready  in  1  packetizer accept.
- out_dest  out  ADDR_W  registered dest address.
- out_opcode  out  OP_W  registered opcode.
- out_data  out  DATA_W  registered payload.
- grant_id  out  $clog2(NUM_REQ)  index of the currently or last granted requester.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=0; burst_cnt=0; out_valid=0; out_dest/out_opcode/out_data=0; grant_id=0; busy=0; req_ready=0.
- Handshake rule: a transfer occurs on a clock edge where valid&&ready. Requester fields are sampled only on the cycle req_ready[i]=1.
- req_ready is combinational from state and req_valid. It is never asserted while out_valid=1 and out_ready=0.
- FSM states: IDLE, HOLD, LOCK.
- IDLE:
  - Select the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around.
  - Assert req_ready[i] in the same cycle.
  - On the edge: register the fields, out_valid=1, grant_id=i, burst_cnt=1, go to HOLD.
  - No request: stay in IDLE.
- HOLD:
  - out_valid=1 and fields stable until out_ready=1.
  - On the out_ready edge, if req_valid[grant_id]=1 and burst_cnt<MAX_BURST, go to LOCK.
  - Otherwise: rr_ptr=(grant_id+1) mod NUM_REQ, out_valid=0, go to IDLE.
- LOCK (burst continuation):
  - Combinationally, req_ready[grant_id]=1 if req_valid[grant_id]=1.
  - Accept: register the fields, out_valid=1, burst_cnt++, go to HOLD.
  - If the requester dropped req_valid: rr_ptr=grant_id+1 mod NUM_REQ, go to IDLE.
- Latency: req accept at edge t gives out_valid high after edge t, i.e. 1 cycle. Sustained throughput is 1 packet per 2 cycles.
- Simultaneous requests: only one winner per cycle; losers see req_ready=0 and must hold their fields.
- Fairness: with all requesters continuously valid, each gets exactly MAX_BURST packets per rotation.
- MAX_BURST=1: LOCK is never entered; pure round-robin.
- Requester withdraws req_valid before its grant: no error; it is simply skipped.
- out_ready high while out_valid=0: ignored.
- Reset mid-packet: out_valid drops immediately on reset assertion and the in-flight packet is discarded. After release, arbitration restarts from requester 0.
- burst_cnt width is $clog2(MAX_BURST+1). It never wraps because it saturates at MAX_BURST by construction.

Optional Feature:
- SPE_TX_ARB_PRIO0_EN.
- Defined: requester 0 is a high-priority control source. In IDLE, req_valid[0]=1 wins regardless of rr_ptr. A LOCK burst by another requester is terminated after the current packet if req_valid[0]=1, and the FSM returns to IDLE. rr_ptr is not advanced by requester-0 grants.
- Undefined: requester 0 is an ordinary round-robin participant.

Test Plan:
- Reset, then a single requester 2 with dest=4'h5, opcode=4'h3, data=25'h1ABCDE, out_ready=1 -> req_ready[2] pulses 1 cycle; next cycle out_valid=1 with those fields and grant_id=2; back to IDLE after one cycle.
- All 4 valid continuously, MAX_BURST=4, out_ready=1 -> grant order 0,0,0,0,1,1,1,1,2,...; 16 packets in 32 cycles; no requester gets more than 4 in a row.
- out_ready held 0 for 10 cycles with a packet in HOLD -> out_* stable; all req_ready=0 throughout; transfer completes on the cycle out_ready rises.
- Requester 1 drops req_valid after 2 packets of a burst -> LOCK to IDLE; rr_ptr=2; requester 2 or 3 served next if valid.
- Assert reset while in HOLD with out_valid=1 -> out_valid=0 within the same cycle (async); after release, with requesters 3 and 0 valid, requester 0 is granted first.
- SPE_TX_ARB_PRIO0_EN defined, requester 3 bursting, req_valid[0] rises -> requester 3's burst ends after its current packet; next grant_id=0; rr_ptr unchanged.

Source files
------------

// File: rtl/spe_tx_arbiter.sv
// Round-robin arbiter feeding one SPE packetizer input from NUM_REQ requesters, with bounded burst lock.
// Optional macro SPE_TX_ARB_PRIO0_EN: requester 0 becomes a high-priority source that preempts bursts.
module spe_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = 4,
   parameter int OP_W      = 4,
   parameter int DATA_W    = 25,
   parameter int MAX_BURST = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_dest,
   input  logic [NUM_REQ*OP_W-1:0]     req_opcode,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ADDR_W-1:0]           out_dest,
   output logic [OP_W-1:0]             out_opcode,
   output logic [DATA_W-1:0]           out_data,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        busy
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [ADDR_W-1:0]   out_dest_q;
   logic [OP_W-1:0]     out_opcode_q;
   logic [DATA_W-1:0]   out_data_q;

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [NUM_REQ-1:0]   grant_oh;
   logic                 sel_found;
   logic [GW-1:0]        sel_idx;
   logic                 grant_vld;
   logic                 preempt;
   logic                 rr_adv;
   logic                 load;
   logic [GW-1:0]        load_idx;
   logic [ADDR_W-1:0]    mux_dest;
   logic [OP_W-1:0]      mux_opcode;
   logic [DATA_W-1:0]    mux_data;

   // Modular add on requester indices; NUM_REQ need not be a power of two.
   function automatic logic [GW-1:0] rr_add(input logic [GW-1:0] base, input int unsigned off);
      logic [GW:0] s;
      s = {1'b0, base} + (GW+1)'(off);
      if (s >= (GW+1)'(NUM_REQ))
         s = s - (GW+1)'(NUM_REQ);
      return s[GW-1:0];
   endfunction

   // Rotate the request vector so bit 0 is the requester at rr_ptr, then take the lowest set bit.
   always_comb begin
      req_dbl   = {req_valid, req_valid};
      req_rot   = req_dbl[rr_ptr_q +: NUM_REQ];
      sel_found = 1'b0;
      sel_idx   = rr_ptr_q;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            sel_found = 1'b1;
            sel_idx   = rr_add(rr_ptr_q, unsigned'(k));
         end
      end
`ifdef SPE_TX_ARB_PRIO0_EN
      if (req_valid[0]) begin
         sel_found = 1'b1;
         sel_idx   = '0;
      end
`endif
   end

   assign grant_oh  = NUM_REQ'(1) << grant_q;
   assign grant_vld = |(req_valid & grant_oh);

`ifdef SPE_TX_ARB_PRIO0_EN
   // A pending requester 0 cuts another requester's burst short; rr_ptr then stays put so the
   // preempted requester resumes its turn, and requester-0 grants never move the pointer.
   assign preempt = req_valid[0] && (grant_q != '0);
   assign rr_adv  = (grant_q != '0) && !preempt;
`else
   assign preempt = 1'b0;
   assign rr_adv  = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      burst_cnt_d = burst_cnt_q;
      out_valid_d = out_valid_q;
      req_ready   = '0;
      load        = 1'b0;
      load_idx    = grant_q;
      unique case (state_q)
         IDLE: begin
            if (sel_found) begin
               req_ready   = NUM_REQ'(1) << sel_idx;
               load        = 1'b1;
               load_idx    = sel_idx;
               grant_d     = sel_idx;
               burst_cnt_d = BW'(1);
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (grant_vld && (burst_cnt_q < BW'(MAX_BURST)) && !preempt) begin
                  state_d = LOCK;
               end else begin
                  state_d = IDLE;
                  if (rr_adv)
                     rr_ptr_d = rr_add(grant_q, 1);
               end
            end
         end
         LOCK: begin
            if (grant_vld && !preempt) begin
               req_ready   = grant_oh;
               load        = 1'b1;
               out_valid_d = 1'b1;
               burst_cnt_d = burst_cnt_q + BW'(1);
               state_d     = HOLD;
            end else begin
               state_d = IDLE;
               if (rr_adv)
                  rr_ptr_d = rr_add(grant_q, 1);
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      mux_dest   = '0;
      mux_opcode = '0;
      mux_data   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (GW'(k) == load_idx) begin
            mux_dest   = req_dest[k*ADDR_W +: ADDR_W];
            mux_opcode = req_opcode[k*OP_W +: OP_W];
            mux_data   = req_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         burst_cnt_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         burst_cnt_q <= burst_cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Packet fields are captured only on an accepted request and held until the next accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_dest_q   <= '0;
         out_opcode_q <= '0;
         out_data_q   <= '0;
      end else if (load) begin
         out_dest_q   <= mux_dest;
         out_opcode_q <= mux_opcode;
         out_data_q   <= mux_data;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_dest   = out_dest_q;
   assign out_opcode = out_opcode_q;
   assign out_data   = out_data_q;
   assign grant_id   = grant_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spe_tx_arbiter.sv
// Directed table-driven bench for spe_tx_arbiter (default build, NUM_REQ=4, MAX_BURST=4).
module tb_spe_tx_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic [15:0]   req_dest;
   logic [15:0]   req_opcode;
   logic [99:0]   req_data;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    out_dest;
   logic [3:0]    out_opcode;
   logic [24:0]   out_data;
   logic [1:0]    grant_id;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   logic [3:0]  f_dest [4] = '{4'hA, 4'hB, 4'h5, 4'hC};
   logic [3:0]  f_op   [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
   logic [24:0] f_data [4] = '{25'h0000011, 25'h0000022, 25'h1ABCDE, 25'h0000044};

   typedef struct {
      logic [3:0] vld;
      logic       ordy;
      logic [3:0] e_rdy;
      logic       e_ov;
      logic [1:0] e_g;
      logic       e_busy;
   } vec_t;

   vec_t tv [26];

   spe_tx_arbiter #(
      .NUM_REQ(4), .ADDR_W(4), .OP_W(4), .DATA_W(25), .MAX_BURST(4)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dest(req_dest), .req_opcode(req_opcode), .req_data(req_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_dest(out_dest), .out_opcode(out_opcode), .out_data(out_data),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_fields(input string name, input int g);
      chk({name, "_dest"}, 32'(out_dest),   32'(f_dest[g]));
      chk({name, "_op"},   32'(out_opcode), 32'(f_op[g]));
      chk({name, "_data"}, 32'(out_data),   32'(f_data[g]));
   endtask

   initial begin
      // vld, out_ready, expected req_ready, then out_valid/grant/busy after the edge
      tv[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
      tv[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};
      tv[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};
      tv[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
      tv[4]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1};
      tv[5]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
      tv[6]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1};
      tv[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
      tv[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1};
      tv[9]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
      tv[10] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0};
      tv[11] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
      tv[12] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
      tv[13] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
      tv[14] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};
      tv[15] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};
      tv[16] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};
      tv[17] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
      tv[18] = '{4'b1110, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
      tv[19] = '{4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
      tv[20] = '{4'b1110, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1};
      tv[21] = '{4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
      tv[22] = '{4'b1110, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1};
      tv[23] = '{4'b1100, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0};
      tv[24] = '{4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
      tv[25] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};

      for (int i = 0; i < 4; i++) begin
         req_dest[i*4 +: 4]    = f_dest[i];
         req_opcode[i*4 +: 4]  = f_op[i];
         req_data[i*25 +: 25]  = f_data[i];
      end
      req_valid = '0;
      out_ready = 1'b0;
      reset     = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ov",    32'(out_valid), 32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_grant", 32'(grant_id),  32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_dest",  32'(out_dest),  32'd0);
      chk("rst_data",  32'(out_data),  32'd0);

      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         req_valid = tv[i].vld;
         out_ready = tv[i].ordy;
         #1;
         chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tv[i].e_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ov", i),    32'(out_valid), 32'(tv[i].e_ov));
         chk($sformatf("v%0d_grant", i), 32'(grant_id),  32'(tv[i].e_g));
         chk($sformatf("v%0d_busy", i),  32'(busy),      32'(tv[i].e_busy));
         if (tv[i].e_ov)
            chk_fields($sformatf("v%0d", i), int'(tv[i].e_g));
      end

      // Long stall in HOLD: fields stay put and nobody is accepted (rr_ptr is 3 here).
      @(negedge clk);
      req_valid = 4'b1000;
      out_ready = 1'b0;
      #1;
      chk("stall_acc_ready", 32'(req_ready), 32'b1000);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req_valid = 4'b1111;
         #1;
         chk($sformatf("stall%0d_ready", c), 32'(req_ready), 32'd0);
         chk($sformatf("stall%0d_ov", c),    32'(out_valid), 32'd1);
         chk($sformatf("stall%0d_g", c),     32'(grant_id),  32'd3);
         chk_fields($sformatf("stall%0d", c), 3);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("stall_rel_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("stall_rel_ov",   32'(out_valid), 32'd0);
      chk("stall_rel_busy", 32'(busy),      32'd1);
      @(negedge clk);
      req_valid = 4'b0000;
      @(posedge clk);
      #1;
      chk("stall_end_busy", 32'(busy), 32'd0);

      // Reset while a packet sits in HOLD, then restart from requester 0.
      @(negedge clk);
      req_valid = 4'b0010;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("prerst_ov", 32'(out_valid), 32'd1);
      chk("prerst_g",  32'(grant_id),  32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_ov",   32'(out_valid), 32'd0);
      chk("midrst_busy", 32'(busy),      32'd0);
      chk("midrst_g",    32'(grant_id),  32'd0);
      chk("midrst_dest", 32'(out_dest),  32'd0);
      @(negedge clk);
      reset     = 1'b0;
      req_valid = 4'b1001;
      out_ready = 1'b1;
      #1;
      chk("postrst_ready", 32'(req_ready), 32'b0001);
      @(posedge clk);
      #1;
      chk("postrst_ov", 32'(out_valid), 32'd1);
      chk("postrst_g",  32'(grant_id),  32'd0);
      chk_fields("postrst", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
